alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 50 +++++
 rtl/alu.sv | 57 +++++
 tb/tb_alu.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Instruction type and function-code constants shared by the ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [1:0] TYPE_A = 2'b00;
  localparam logic [1:0] TYPE_B = 2'b01;
  localparam logic [1:0] TYPE_C = 2'b10;
  localparam logic [1:0] TYPE_D = 2'b11;

  localparam logic [3:0] FN_ADD = 4'b1111;
  localparam logic [3:0] FN_SUB = 4'b1110;
  localparam logic [3:0] FN_AND = 4'b1101;
  localparam logic [3:0] FN_OR  = 4'b1100;
  localparam logic [3:0] FN_MUL = 4'b0001;
  localparam logic [3:0] FN_DIV = 4'b0010;
  localparam logic [3:0] FN_SLL = 4'b1010;
  localparam logic [3:0] FN_SRL = 4'b1011;
  localparam logic [3:0] FN_ROL = 4'b1000;
  localparam logic [3:0] FN_ROR = 4'b1001;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational result datapath; only type A produces a non-zero result.
// Revision : 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
(
  input  logic [1:0]  i_type,
  input  logic [3:0]  i_funct,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result
);

  logic [31:0] w_mul_full;
  logic [31:0] w_rol_wide;
  logic [31:0] w_ror_wide;
  logic [3:0]  w_sh;

  // Rotates shift a doubled copy of A so the wrapped bits fall into the kept half
  always_comb begin
    w_sh       = i_b[3:0];
    w_mul_full = {16'h0000, i_a} * {16'h0000, i_b};
    w_rol_wide = {i_a, i_a} << w_sh;
    w_ror_wide = {i_a, i_a} >> w_sh;
  end

  always_comb begin
    o_result = 16'h0000;
    if (i_type == TYPE_A) begin
      case (i_funct)
        FN_ADD:  o_result = i_a + i_b;
        FN_SUB:  o_result = i_a - i_b;
        FN_AND:  o_result = i_a & i_b;
        FN_OR:   o_result = i_a | i_b;
        FN_MUL:  o_result = w_mul_full[15:0];
        FN_DIV:  o_result = (i_b == 16'h0000) ? 16'hFFFF : (i_a / i_b);
        FN_SLL:  o_result = i_a << w_sh;
        FN_SRL:  o_result = i_a >> w_sh;
        FN_ROL:  o_result = w_rol_wide[31:16];
        FN_ROR:  o_result = w_ror_wide[15:0];
        default: o_result = 16'h0000;
      endcase
    end
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Instruction field split plus one-cycle registered ALU result.
// Revision : 1.0
// ============================================================================
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inp,
  output logic [15:0] out
);

  logic [1:0]  instr_type;
  logic [1:0]  sub_id_unused;
  logic [3:0]  funct;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] core_result;
  logic [15:0] out_d;
  logic [15:0] out_q;

  // The sub-identifier carries no meaning here: types B/C/D all yield zero
  always_comb begin
    instr_type    = inp[15:14];
    sub_id_unused = inp[13:12];
    op_a          = {12'h000, inp[11:8]};
    op_b          = {12'h000, inp[7:4]};
    funct         = inp[3:0];
  end

  alu_core u_core (
    .i_type   (instr_type),
    .i_funct  (funct),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_result (core_result)
  );

  always_comb begin
    out_d = core_result;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Directed self-checking bench for alu with hand-computed results.
// Revision : 1.0
// ============================================================================
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] inp;
  logic [15:0] out;

  int checks;
  int errors;

  alu dut (
    .clk (clk),
    .rst (rst),
    .inp (inp),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] expected);
    checks++;
    assert (out === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, out, expected);
    end
  endtask

  // Present inputs away from the active edge, clock once, sample 1 ns later
  task automatic step(input logic rst_v, input logic [15:0] inp_v,
                      input string tag, input logic [15:0] expected);
    @(negedge clk);
    rst = rst_v;
    inp = inp_v;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    inp    = 16'hFFFF;

    step(1'b0, 16'hFFFF, "reset_edge1", 16'h0000);
    step(1'b0, 16'h081F, "reset_edge2", 16'h0000);

    step(1'b1, 16'h081F, "add_8_1", 16'h0009);
    step(1'b1, 16'h081E, "sub_8_1", 16'h0007);
    step(1'b1, 16'h081D, "and_8_1", 16'h0000);
    step(1'b1, 16'h081C, "or_8_1",  16'h0009);

    step(1'b1, 16'h0811, "mul_8_1", 16'h0008);
    step(1'b1, 16'h0812, "div_8_1", 16'h0008);
    step(1'b1, 16'h081A, "sll_8_1", 16'h0010);
    step(1'b1, 16'h081B, "srl_8_1", 16'h0004);
    step(1'b1, 16'h0818, "rol_8_1", 16'h0010);
    step(1'b1, 16'h0819, "ror_8_1", 16'h0004);

    step(1'b1, 16'h018E, "sub_wrap_1_8",  16'hFFF9);
    step(1'b1, 16'h0802, "div_by_zero",   16'hFFFF);
    step(1'b1, 16'h08F8, "rol_8_15",      16'h0004);
    step(1'b1, 16'h0FF1, "mul_15_15",     16'h00E1);
    step(1'b1, 16'h0FFF, "add_15_15",     16'h001E);
    step(1'b1, 16'h0F3A, "sll_15_3",      16'h0078);
    step(1'b1, 16'h0F29, "ror_15_2",      16'hC003);
    step(1'b1, 16'h0C52, "div_12_5",      16'h0002);

    step(1'b1, 16'h080A, "sll_amt0", 16'h0008);
    step(1'b1, 16'h080B, "srl_amt0", 16'h0008);
    step(1'b1, 16'h0808, "rol_amt0", 16'h0008);
    step(1'b1, 16'h0809, "ror_amt0", 16'h0008);

    step(1'b1, 16'h481F, "type_b_add",  16'h0000);
    step(1'b1, 16'h0BBF, "add_11_11",   16'h0016);
    step(1'b1, 16'h8FFF, "type_c",      16'h0000);
    step(1'b1, 16'hF81F, "type_d",      16'h0000);
    step(1'b1, 16'h0810, "type_a_f0",   16'h0000);
    step(1'b1, 16'h0817, "type_a_f7",   16'h0000);

    // Hold stability: same input for two edges, and steady between edges
    step(1'b1, 16'h0C3F, "hold_first",  16'h000F);
    step(1'b1, 16'h0C3F, "hold_second", 16'h000F);
    @(negedge clk);
    check("between_edges", 16'h000F);

    // Reset has no asynchronous effect, then wins over a presented add
    step(1'b1, 16'h081F, "pre_reset_add", 16'h0009);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("no_async_reset", 16'h0009);
    @(posedge clk);
    #1;
    check("midstream_reset", 16'h0000);
    step(1'b1, 16'h081F, "release_reset", 16'h0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu
`default_nettype wire
